// File: rtl/cella_pkg.sv
// Shared types and defaults for the CELLA 4x4 CAM/MAC array controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cella_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_SEARCH = 2'd1,
    OP_MAC    = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACT  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/cella_popcount.sv
// Counts the set bits of one sense-amp word for the MAC accumulator.
// Latency: combinational.
// Backpressure: none.
module cella_popcount #(
  parameter int COLS  = 4,
  parameter int CNT_W = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0]  bits_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Simple adder chain; COLS is small so depth is not a concern.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < COLS; i++) begin
      cnt_o = cnt_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/cella_array_ctrl.sv
// Command sequencer for one CELLA 4x4 CAM/MAC macro (PRE/ACT timing, match/sense sampling).
// Latency: WRITE/SEARCH PRE+PULSE cycles, MAC that per enabled row, reserved/empty-mask 1 cycle.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Macro CELLA_WRITE_VERIFY_EN adds a WRITE read-back.
module cella_array_ctrl
  import cella_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int ADDR_W       = $clog2(ROWS),
  parameter int PRE_CYCLES   = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int RSP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [COLS-1:0]   cmd_data,
  input  logic              cmd_rdbar,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RSP_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              arr_cs,
  output logic              arr_w_en,
  output logic              arr_mac_en,
  output logic              arr_read_bar,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [COLS-1:0]   arr_data,
  input  logic [ROWS-1:0]   arr_ml,
  input  logic [COLS-1:0]   arr_sa
);

  localparam int PC_W   = $clog2(COLS + 1);
  localparam int CNT_MX = (PRE_CYCLES > PULSE_CYCLES) ? PRE_CYCLES : PULSE_CYCLES;
  localparam int CNT_W  = $clog2(CNT_MX + 1);

  // Sequencer state and latched command
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [COLS-1:0]   data_q, data_d;
  logic              rdbar_q, rdbar_d;
  logic [RSP_W-1:0]  acc_q, acc_d;
  logic              vfy_q, vfy_d;

  // Registered outputs
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cs_q, cs_d;
  logic              wen_q, wen_d;
  logic              macen_q, macen_d;
  logic              rb_q, rb_d;
  logic [ADDR_W-1:0] aaddr_q, aaddr_d;
  logic [COLS-1:0]   adata_q, adata_d;

  op_e               cmd_op_e;
  logic [PC_W-1:0]   sa_cnt;
  logic [RSP_W-1:0]  acc_sum;
  logic [ADDR_W:0]   first_row;
  logic [ADDR_W:0]   next_row_v;
  logic              pre_done;
  logic              act_done;

  assign cmd_op_e = op_e'(cmd_op);

  // Lowest enabled row strictly above 'after'; MSB of the result flags "found".
  function automatic logic [ADDR_W:0] next_row(input logic [COLS-1:0] mask, input int after);
    logic [ADDR_W:0] res;
    res = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (r > after && r < COLS && mask[r]) begin
        res = {1'b1, ADDR_W'(r)};
      end
    end
    return res;
  endfunction

  cella_popcount #(
    .COLS  (COLS),
    .CNT_W (PC_W)
  ) u_popcount (
    .bits_i (arr_sa),
    .cnt_o  (sa_cnt)
  );

  // Next-state, command latching, sampling and the registered-output image.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    row_d       = row_q;
    data_d      = data_q;
    rdbar_d     = rdbar_q;
    acc_d       = acc_q;
    vfy_d       = vfy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    first_row  = next_row(cmd_data, -1);
    next_row_v = next_row(data_q, int'(row_q));
    acc_sum    = acc_q + RSP_W'(sa_cnt);
    pre_done   = (cnt_q == CNT_W'(PRE_CYCLES - 1));
    act_done   = (cnt_q == CNT_W'(PULSE_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op_e;
          row_d      = cmd_addr;
          data_d     = cmd_data;
          rdbar_d    = cmd_rdbar;
          acc_d      = '0;
          vfy_d      = 1'b0;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (cmd_op_e == OP_RSVD) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else if (cmd_op_e == OP_MAC && !first_row[ADDR_W]) begin
            state_d = RESP;
          end else begin
            state_d = PRE;
            if (cmd_op_e == OP_MAC) begin
              row_d = first_row[ADDR_W-1:0];
            end
          end
        end
      end
      PRE: begin
        if (pre_done) begin
          state_d = ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACT: begin
        if (!act_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (op_q)
            OP_WRITE: begin
`ifdef CELLA_WRITE_VERIFY_EN
              if (!vfy_q) begin
                vfy_d   = 1'b1;
                state_d = PRE;
              end else begin
                rsp_err_d   = (arr_sa != data_q);
                state_d     = RESP;
                rsp_valid_d = 1'b1;
              end
`else
              state_d     = RESP;
              rsp_valid_d = 1'b1;
`endif
            end
            OP_SEARCH: begin
              rsp_data_d  = RSP_W'(arr_ml);
              state_d     = RESP;
              rsp_valid_d = 1'b1;
            end
            OP_MAC: begin
              acc_d = acc_sum;
              if (next_row_v[ADDR_W]) begin
                row_d   = next_row_v[ADDR_W-1:0];
                state_d = PRE;
              end else begin
                rsp_data_d  = acc_sum;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
              end
            end
            default: begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
            end
          endcase
        end
      end
      RESP: begin
        // Commands that skip the array land here with rsp_valid low and
        // raise it one cycle later, giving them a uniform 1-cycle latency.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Array controls for the coming cycle; address/data are set up in PRE
    // so they are already stable when cs rises.
    cmd_ready_d = (state_d == IDLE);
    cs_d        = 1'b0;
    wen_d       = 1'b0;
    macen_d     = 1'b0;
    rb_d        = 1'b0;
    aaddr_d     = '0;
    adata_d     = '0;
    if (state_d == PRE || state_d == ACT) begin
      aaddr_d = row_d;
      rb_d    = (op_d == OP_MAC) && rdbar_d;
      if (op_d != OP_MAC && !vfy_d) begin
        adata_d = data_d;
      end
      if (state_d == ACT) begin
        cs_d    = 1'b1;
        wen_d   = (op_d == OP_WRITE) && !vfy_d;
        macen_d = (op_d == OP_MAC) || vfy_d;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_WRITE;
      row_q       <= '0;
      data_q      <= '0;
      rdbar_q     <= 1'b0;
      acc_q       <= '0;
      vfy_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cs_q        <= 1'b0;
      wen_q       <= 1'b0;
      macen_q     <= 1'b0;
      rb_q        <= 1'b0;
      aaddr_q     <= '0;
      adata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      row_q       <= row_d;
      data_q      <= data_d;
      rdbar_q     <= rdbar_d;
      acc_q       <= acc_d;
      vfy_q       <= vfy_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cs_q        <= cs_d;
      wen_q       <= wen_d;
      macen_q     <= macen_d;
      rb_q        <= rb_d;
      aaddr_q     <= aaddr_d;
      adata_q     <= adata_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign arr_cs       = cs_q;
  assign arr_w_en     = wen_q;
  assign arr_mac_en   = macen_q;
  assign arr_read_bar = rb_q;
  assign arr_addr     = aaddr_q;
  assign arr_data     = adata_q;

endmodule

// File: tb/tb_cella_array_ctrl.sv
// Self-checking bench for cella_array_ctrl with a behavioural CAM/MAC array.
// Latency: n/a.
// Backpressure: exercises held responses and back-to-back commands.
module tb_cella_array_ctrl;

  localparam int PRE   = 1;
  localparam int PULSE = 2;
`ifdef CELLA_WRITE_VERIFY_EN
  localparam int WR_LAT = 2 * (PRE + PULSE);
`else
  localparam int WR_LAT = PRE + PULSE;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rdbar;
  logic [1:0] cmd_op, cmd_addr;
  logic [3:0] cmd_data;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;
  logic       arr_cs, arr_w_en, arr_mac_en, arr_read_bar;
  logic [1:0] arr_addr;
  logic [3:0] arr_data, arr_ml, arr_sa;

  always #5 clk = ~clk;

  cella_array_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rdbar(cmd_rdbar),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .arr_cs(arr_cs), .arr_w_en(arr_w_en), .arr_mac_en(arr_mac_en),
    .arr_read_bar(arr_read_bar), .arr_addr(arr_addr), .arr_data(arr_data),
    .arr_ml(arr_ml), .arr_sa(arr_sa)
  );

  // Behavioural array: real contents, inverted (wrong) outputs when not in the matching access.
  logic [3:0] arr_mem [4] = '{default: 4'h0};
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_ml = 4'h0, ovr_sa = 4'h0;
  logic [3:0] ml_val, sa_val;

  always_comb begin
    for (int r = 0; r < 4; r++) ml_val[r] = (arr_mem[r] == arr_data);
    sa_val = arr_read_bar ? ~arr_mem[arr_addr] : arr_mem[arr_addr];
    if (ovr_en) begin
      ml_val = ovr_ml;
      sa_val = ovr_sa;
    end
    arr_ml = (arr_cs && !arr_w_en && !arr_mac_en) ? ml_val : ~ml_val;
    arr_sa = (arr_cs && arr_mac_en) ? sa_val : ~sa_val;
  end

  always @(posedge clk) if (arr_cs && arr_w_en) arr_mem[arr_addr] <= arr_data;

  // Reference model: command-level view of contents and expected access list.
  typedef struct packed {
    logic cs, w, m, rb, chk_a, chk_d;
    logic [1:0] a;
    logic [3:0] d;
  } tr_t;

  logic [3:0] ref_mem [4] = '{default: 4'h0};
  tr_t        tr[$];
  tr_t        etr[$];
  int         exp_lat;
  logic [7:0] exp_data;
  logic       exp_err;
  int         n_pass = 0, n_total = 0;

  task automatic add_access(input logic w, input logic m, input logic rb, input logic chk_a,
                            input logic [1:0] a, input logic chk_d, input logic [3:0] d);
    tr_t e;
    e = '0;
    for (int i = 0; i < PRE; i++) etr.push_back(e);
    e.cs = 1'b1; e.w = w; e.m = m; e.rb = rb; e.chk_a = chk_a; e.a = a; e.chk_d = chk_d; e.d = d;
    for (int i = 0; i < PULSE; i++) etr.push_back(e);
  endtask

  task automatic predict(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data,
                         input logic rdbar);
    int n_acc;
    int sum;
    logic [3:0] rb_word;
    n_acc = 0; sum = 0;
    etr.delete();
    exp_data = 8'h00;
    exp_err  = 1'b0;
    case (op)
      2'd0: begin
        add_access(1'b1, 1'b0, 1'b0, 1'b1, addr, 1'b1, data);
        n_acc = 1;
        ref_mem[addr] = data;
`ifdef CELLA_WRITE_VERIFY_EN
        add_access(1'b0, 1'b1, 1'b0, 1'b1, addr, 1'b0, 4'h0);
        n_acc = 2;
        rb_word = ovr_en ? ovr_sa : ref_mem[addr];
        exp_err = (rb_word != data);
`endif
      end
      2'd1: begin
        add_access(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, data);
        n_acc = 1;
        for (int r = 0; r < 4; r++) exp_data[r] = ovr_en ? ovr_ml[r] : (ref_mem[r] == data);
      end
      2'd2: begin
        for (int r = 0; r < 4; r++) begin
          if (data[r]) begin
            add_access(1'b0, 1'b1, rdbar, 1'b1, 2'(r), 1'b0, 4'h0);
            n_acc++;
            rb_word = ovr_en ? ovr_sa : (rdbar ? ~ref_mem[r] : ref_mem[r]);
            sum += $countones(rb_word);
          end
        end
        exp_data = 8'(sum);
      end
      default: exp_err = 1'b1;
    endcase
    if (n_acc == 0) begin
      etr.push_back('0);
      exp_lat = 1;
    end else begin
      exp_lat = n_acc * (PRE + PULSE);
    end
  endtask

  // Drive one command and record the array controls until rsp_valid; lat=-1 on timeout.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data,
                         input logic rdbar, output int lat, output int waits);
    tr_t s;
    tr.delete();
    lat = -1;
    waits = 0;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_rdbar = rdbar; cmd_valid = 1'b1;
    while (!cmd_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      s = '0;
      s.cs = arr_cs; s.w = arr_w_en; s.m = arr_mac_en; s.rb = arr_read_bar;
      s.a = arr_addr; s.d = arr_data;
      tr.push_back(s);
      @(posedge clk); #1;
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  function automatic int trace_diff();
    if (tr.size() != etr.size()) return -2;
    foreach (tr[i]) begin
      if (tr[i].cs !== etr[i].cs) return i;
      if (etr[i].cs) begin
        if (tr[i].w !== etr[i].w || tr[i].m !== etr[i].m || tr[i].rb !== etr[i].rb) return i;
        if (etr[i].chk_a && tr[i].a !== etr[i].a) return i;
        if (etr[i].chk_d && tr[i].d !== etr[i].d) return i;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_rsp: got rdy/vld/err/data %b%b%b %h want 1 0 0 00",
               cmd_ready, rsp_valid, rsp_err, rsp_data);
    else n_pass++;
    n_total++;
    if ({arr_cs, arr_w_en, arr_mac_en, arr_read_bar, arr_addr, arr_data} !== 10'b0)
      $display("FAIL reset_arr: got cs/w/m/rb/a/d %b%b%b%b %0d %b want all 0",
               arr_cs, arr_w_en, arr_mac_en, arr_read_bar, arr_addr, arr_data);
    else n_pass++;

    // Reset while a MAC is in its ACT phase.
    cmd_op = 2'd2; cmd_addr = 2'd0; cmd_data = 4'hF; cmd_rdbar = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !arr_cs; i++) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (arr_cs !== 1'b1) $display("FAIL mac_reach_act: got cs=%b want 1", arr_cs);
    else n_pass++;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if ({arr_cs, rsp_valid, cmd_ready} !== 3'b001)
      $display("FAIL mid_reset: got cs/vld/rdy %b%b%b want 001", arr_cs, rsp_valid, cmd_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({arr_cs, rsp_valid, cmd_ready} !== 3'b001)
      $display("FAIL post_reset_idle: got cs/vld/rdy %b%b%b want 001", arr_cs, rsp_valid, cmd_ready);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid || arr_cs) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL dropped_cmd: got activity=%b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_write();
    int lat, wn, d;
    ovr_en = 1'b0;
    predict(2'd0, 2'd2, 4'b1010, 1'b0);
    run_cmd(2'd0, 2'd2, 4'b1010, 1'b0, lat, wn);
    d = trace_diff();
    n_total++;
    if (lat !== WR_LAT) $display("FAIL write_lat: got %0d want %0d", lat, WR_LAT);
    else n_pass++;
    n_total++;
    if (d !== -1) $display("FAIL write_trace: first bad entry %0d want -1", d);
    else n_pass++;
    n_total++;
    if ({rsp_data, rsp_err} !== 9'h000)
      $display("FAIL write_rsp: got data=%h err=%b want 00 0", rsp_data, rsp_err);
    else n_pass++;
    accept_rsp();
  endtask

  task automatic test_search_hold();
    int lat, wn, d;
    ovr_en = 1'b1; ovr_ml = 4'b0100;
    predict(2'd1, 2'd0, 4'b0110, 1'b0);
    run_cmd(2'd1, 2'd0, 4'b0110, 1'b0, lat, wn);
    d = trace_diff();
    n_total++;
    if (lat !== 3) $display("FAIL search_lat: got %0d want 3", lat);
    else n_pass++;
    n_total++;
    if (rsp_data !== 8'h04) $display("FAIL search_data: got %h want 04", rsp_data);
    else n_pass++;
    n_total++;
    if (d !== -1) $display("FAIL search_trace: first bad entry %0d want -1", d);
    else n_pass++;
    // A competing command is offered while the response is stalled.
    cmd_op = 2'd0; cmd_addr = 2'd3; cmd_data = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({rsp_valid, rsp_data, cmd_ready, arr_cs} !== {1'b1, 8'h04, 1'b0, 1'b0})
        $display("FAIL search_hold%0d: got vld=%b data=%h rdy=%b cs=%b want 1 04 0 0",
                 i, rsp_valid, rsp_data, cmd_ready, arr_cs);
      else n_pass++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    accept_rsp();
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL search_release: got vld=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    else n_pass++;
    ovr_en = 1'b0;
  endtask

  task automatic test_mac();
    int lat, wn, d;
    ovr_en = 1'b1; ovr_sa = 4'b1110;
    predict(2'd2, 2'd0, 4'b1011, 1'b1);
    run_cmd(2'd2, 2'd0, 4'b1011, 1'b1, lat, wn);
    d = trace_diff();
    n_total++;
    if (lat !== 9) $display("FAIL mac_lat: got %0d want 9", lat);
    else n_pass++;
    n_total++;
    if ({rsp_data, rsp_err} !== {8'd9, 1'b0})
      $display("FAIL mac_data: got data=%0d err=%b want 9 0", rsp_data, rsp_err);
    else n_pass++;
    n_total++;
    if (d !== -1) $display("FAIL mac_rows: first bad entry %0d want -1", d);
    else n_pass++;
    accept_rsp();
    ovr_en = 1'b0;
  endtask

  task automatic test_mac_zero_rsvd();
    int lat, wn, d;
    predict(2'd2, 2'd1, 4'b0000, 1'b1);
    run_cmd(2'd2, 2'd1, 4'b0000, 1'b1, lat, wn);
    d = trace_diff();
    n_total++;
    if (lat !== 1) $display("FAIL mask0_lat: got %0d want 1", lat);
    else n_pass++;
    n_total++;
    if ({rsp_data, rsp_err, d} !== {8'h00, 1'b0, -32'sd1})
      $display("FAIL mask0_rsp: got data=%h err=%b trace=%0d want 00 0 -1", rsp_data, rsp_err, d);
    else n_pass++;
    accept_rsp();
    predict(2'd3, 2'd1, 4'b1111, 1'b0);
    run_cmd(2'd3, 2'd1, 4'b1111, 1'b0, lat, wn);
    d = trace_diff();
    n_total++;
    if (lat !== 1) $display("FAIL rsvd_lat: got %0d want 1", lat);
    else n_pass++;
    n_total++;
    if ({rsp_data, rsp_err, d} !== {8'h00, 1'b1, -32'sd1})
      $display("FAIL rsvd_rsp: got data=%h err=%b trace=%0d want 00 1 -1", rsp_data, rsp_err, d);
    else n_pass++;
    accept_rsp();
  endtask

`ifdef CELLA_WRITE_VERIFY_EN
  task automatic test_write_verify();
    int lat, wn, d;
    ovr_en = 1'b1; ovr_sa = 4'b0111;
    predict(2'd1, 2'd1, 4'b0011, 1'b0);
    predict(2'd0, 2'd1, 4'b0011, 1'b0);
    run_cmd(2'd0, 2'd1, 4'b0011, 1'b0, lat, wn);
    d = trace_diff();
    n_total++;
    if ({lat, rsp_err, d} !== {32'sd6, 1'b1, -32'sd1})
      $display("FAIL verify_bad: got lat=%0d err=%b trace=%0d want 6 1 -1", lat, rsp_err, d);
    else n_pass++;
    accept_rsp();
    ovr_sa = 4'b0011;
    predict(2'd0, 2'd1, 4'b0011, 1'b0);
    run_cmd(2'd0, 2'd1, 4'b0011, 1'b0, lat, wn);
    n_total++;
    if ({lat, rsp_err} !== {32'sd6, 1'b0})
      $display("FAIL verify_ok: got lat=%0d err=%b want 6 0", lat, rsp_err);
    else n_pass++;
    accept_rsp();
    ovr_en = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int lat, wn;
    logic [3:0] v;
    v = 4'($urandom_range(1, 15));
    predict(2'd3, 2'd0, v, 1'b0);
    predict(2'd0, 2'd3, v, 1'b0);
    run_cmd(2'd0, 2'd3, v, 1'b0, lat, wn);
    accept_rsp();
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", cmd_ready);
    else n_pass++;
    predict(2'd1, 2'd0, v, 1'b0);
    run_cmd(2'd1, 2'd0, v, 1'b0, lat, wn);
    n_total++;
    if ({wn, lat, rsp_data} !== {32'sd0, 32'sd3, exp_data})
      $display("FAIL b2b_search: got wait=%0d lat=%0d data=%h want 0 3 %h", wn, lat, rsp_data, exp_data);
    else n_pass++;
    accept_rsp();
  endtask

  task automatic test_random();
    int lat, wn, d, hold;
    logic [1:0] op, addr;
    logic [3:0] data;
    logic rdbar;
    for (int it = 0; it < 40; it++) begin
      op    = 2'($urandom_range(0, 3));
      addr  = 2'($urandom_range(0, 3));
      data  = 4'($urandom_range(0, 15));
      rdbar = 1'($urandom_range(0, 1));
      if (op == 2'd1 && $urandom_range(0, 1) == 1) data = ref_mem[addr];
      predict(op, addr, data, rdbar);
      run_cmd(op, addr, data, rdbar, lat, wn);
      d = trace_diff();
      n_total++;
      if (lat !== exp_lat) $display("FAIL rnd%0d_lat: op=%0d got %0d want %0d", it, op, lat, exp_lat);
      else n_pass++;
      n_total++;
      if (d !== -1) $display("FAIL rnd%0d_trace: op=%0d bad entry %0d want -1", it, op, d);
      else n_pass++;
      n_total++;
      if ({rsp_data, rsp_err} !== {exp_data, exp_err})
        $display("FAIL rnd%0d_rsp: op=%0d got data=%h err=%b want %h %b",
                 it, op, rsp_data, rsp_err, exp_data, exp_err);
      else n_pass++;
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        n_total++;
        if ({rsp_valid, rsp_data} !== {1'b1, exp_data})
          $display("FAIL rnd%0d_hold: got vld=%b data=%h want 1 %h", it, rsp_valid, rsp_data, exp_data);
        else n_pass++;
      end
      accept_rsp();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_addr = 2'd0; cmd_data = 4'h0; cmd_rdbar = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_search_hold();
    test_mac();
    test_mac_zero_rsvd();
`ifdef CELLA_WRITE_VERIFY_EN
    test_write_verify();
`endif
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
